// File: rtl/grid_level_streamer_if.sv
// Level ROM read port and grid RAM write port of the grid level streamer.
// The streamer is the master; ROM and grid memory sit on the slave side.
interface grid_level_streamer_if #(
    parameter int X_BITS     = 6,
    parameter int Y_BITS     = 5,
    parameter int CELL_BITS  = 3,
    parameter int LEVEL_BITS = 2
);
    logic [LEVEL_BITS-1:0] rom_level;
    logic [X_BITS-1:0]     rom_x;
    logic [Y_BITS-1:0]     rom_y;
    logic [CELL_BITS-1:0]  rom_data;
    logic [X_BITS-1:0]     grid_x;
    logic [Y_BITS-1:0]     grid_y;
    logic [CELL_BITS-1:0]  grid_in;
    logic                  grid_write;
    logic                  grid_ready;

    modport master (
        output rom_level,
        output rom_x,
        output rom_y,
        input  rom_data,
        output grid_x,
        output grid_y,
        output grid_in,
        output grid_write,
        input  grid_ready
    );

    modport slave (
        input  rom_level,
        input  rom_x,
        input  rom_y,
        output rom_data,
        input  grid_x,
        input  grid_y,
        input  grid_in,
        input  grid_write,
        output grid_ready
    );
endinterface

// File: rtl/grid_level_streamer.sv
// Walks a GRID_W x GRID_H grid row-major, copying a level ROM (or a fill
// value) into grid memory over a ready/valid write port.
module grid_level_streamer #(
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int X_BITS      = 6,
    parameter int Y_BITS      = 5,
    parameter int CELL_BITS   = 3,
    parameter int NUM_LEVELS  = 4,
    parameter int LEVEL_BITS  = 2,
    parameter int ROM_LATENCY = 1,
    parameter int FILL_VALUE  = 0,
    parameter int CNT_BITS    = 11
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  clear_mode,
    input  logic [LEVEL_BITS-1:0] level,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_BITS-1:0]   cell_count,
    grid_level_streamer_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int LAT_W = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;
    localparam logic [LAT_W-1:0]     LAT_INIT = LAT_W'(ROM_LATENCY);
    localparam logic [X_BITS-1:0]    X_LAST   = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0]    Y_LAST   = Y_BITS'(GRID_H - 1);
    localparam logic [CELL_BITS-1:0] FILL     = CELL_BITS'(FILL_VALUE);

    logic [1:0]            r_state;
    logic [X_BITS-1:0]     r_x;
    logic [Y_BITS-1:0]     r_y;
    logic [LEVEL_BITS-1:0] r_level;
    logic                  r_clear;
    logic [LAT_W-1:0]      r_lat;
    logic [CELL_BITS-1:0]  r_data;
    logic [CNT_BITS-1:0]   r_count;
    logic                  r_err;

    logic                  w_bad_level;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_x_wrap;
    logic [CELL_BITS-1:0]  w_cell;

    assign w_bad_level = 32'(level) >= NUM_LEVELS;
    assign w_accept    = (r_state == S_WRITE) && bus.grid_ready;
    assign w_x_wrap    = (r_x == X_LAST);
    assign w_last      = w_x_wrap && (r_y == Y_LAST);
    assign w_cell      = r_clear ? FILL : r_data;

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign err           = done && r_err;
    assign cell_count    = r_count;
    assign bus.rom_level = r_level;
    assign bus.rom_x     = r_x;
    assign bus.rom_y     = r_y;
    assign bus.grid_x    = r_x;
    assign bus.grid_y    = r_y;
    assign bus.grid_in   = w_cell;
    assign bus.grid_write = (r_state == S_WRITE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_level <= '0;
            r_clear <= 1'b0;
            r_lat   <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_level <= level;
                        r_clear <= clear_mode;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        if (w_bad_level) begin
                            r_state <= S_DONE;
                            r_err   <= 1'b1;
                        end else if (clear_mode) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_FETCH;
                            r_lat   <= LAT_INIT;
                        end
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                    end else if (r_lat == '0) begin
                        r_data  <= bus.rom_data;
                        r_state <= S_WRITE;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                S_WRITE: begin
                    // An accept on the abort edge still counts.
                    if (w_accept && (w_cell != '0) && (r_count != '1))
                        r_count <= r_count + CNT_BITS'(1);
                    if (abort) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                    end else if (w_accept) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_err   <= 1'b0;
                        end else begin
                            if (w_x_wrap) begin
                                r_x <= '0;
                                r_y <= r_y + Y_BITS'(1);
                            end else begin
                                r_x <= r_x + X_BITS'(1);
                            end
                            if (!r_clear) begin
                                r_state <= S_FETCH;
                                r_lat   <= LAT_INIT;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
